// File: rtl/if_stage_pkg.sv
// if_stage_pkg: shared widths, parameter defaults, the NOP encoding and the
// return-stack operation decode used by the fetch stage.
`ifndef INSTRUCTION_LEN
`define INSTRUCTION_LEN 32
`endif
`ifndef WORD_LEN
`define WORD_LEN 16
`endif

package if_stage_pkg;
    localparam int INSTR_LEN = `INSTRUCTION_LEN;
    localparam int PC_LEN_DEF = 12;
    localparam int STACK_DEPTH_DEF = 8;
    localparam logic [INSTR_LEN-1:0] NOP = '0;

    typedef enum logic [1:0] {OP_NONE, OP_PUSH, OP_POP, OP_SWAP} stack_op_e;

    // A push+pop pair on an empty stack leaves it empty; the pushed value is forwarded instead.
    function automatic stack_op_e stack_op(input logic push, input logic pop,
                                           input logic full, input logic empty);
        return (push && pop) ? (empty ? OP_NONE : OP_SWAP) :
               push ? (full ? OP_NONE : OP_PUSH) :
               (pop && !empty) ? OP_POP : OP_NONE;
    endfunction
endpackage

// File: rtl/if_stage_return_stack.sv
// return_stack: return-address LIFO; top is the most recent entry,
// push+pop replaces the top in place, full pushes and empty pops are dropped.
module return_stack
    import if_stage_pkg::*;
#(
    parameter int WIDTH = PC_LEN_DEF,
    parameter int DEPTH = STACK_DEPTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      sp;
    logic [AW-1:0]    top_idx;
    stack_op_e        op;

    assign full    = sp == (AW+1)'(DEPTH);
    assign empty   = sp == '0;
    assign top_idx = AW'(sp - 1'b1);
    assign top     = mem[top_idx];
    assign op      = stack_op(push, pop, full, empty);

    always_ff @(posedge clk) begin
        if (rst)
            sp <= '0;
        else if (op == OP_PUSH)
            sp <= sp + 1'b1;
        else if (op == OP_POP)
            sp <= sp - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst && op == OP_PUSH)
            mem[AW'(sp)] <= push_data;
        else if (!rst && op == OP_SWAP)
            mem[top_idx] <= push_data;
    end
endmodule

// File: rtl/if_stage.sv
// if_stage: PC register, return-address stack and IF/ID pipeline register.
// Define IF_STACK_CHECK_EN to get sticky stack_overflow/stack_underflow flags.
module if_stage
    import if_stage_pkg::*;
#(
    parameter int PC_LEN      = PC_LEN_DEF,
    parameter int STACK_DEPTH = STACK_DEPTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 redirect_en,
    input  logic [PC_LEN-1:0]    redirect_pc,
    input  logic                 push_en,
    input  logic [PC_LEN-1:0]    push_pc,
    input  logic                 pop_en,
    output logic [PC_LEN-1:0]    imem_addr,
    input  logic [INSTR_LEN-1:0] imem_data,
    output logic [INSTR_LEN-1:0] PR1_instruction,
    output logic [PC_LEN-1:0]    PR1_pc,
    output logic                 PR1_valid,
    output logic                 stack_overflow,
    output logic                 stack_underflow
);
    logic [PC_LEN-1:0] pc, pc_inc, pc_next, stk_top, pop_pc;
    logic              stk_full, stk_empty, pop_valid;

    return_stack #(.WIDTH(PC_LEN), .DEPTH(STACK_DEPTH)) u_stack (
        .clk       (clk),
        .rst       (rst),
        .push      (push_en),
        .pop       (pop_en),
        .push_data (push_pc),
        .top       (stk_top),
        .full      (stk_full),
        .empty     (stk_empty)
    );

    assign imem_addr = pc;
    assign pc_inc    = pc + 1'b1;
    assign pop_valid = pop_en && (push_en || !stk_empty);
    assign pop_pc    = stk_empty ? push_pc : stk_top;

    always_comb
        pc_next = pop_valid ? pop_pc : redirect_en ? redirect_pc : stall ? pc : pc_inc;

    always_ff @(posedge clk) begin
        if (rst)
            pc <= '0;
        else
            pc <= pc_next;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            PR1_instruction <= NOP;
            PR1_pc          <= '0;
            PR1_valid       <= 1'b0;
        end else if (!stall) begin
            PR1_instruction <= imem_data;
            PR1_pc          <= pc_inc;
            PR1_valid       <= 1'b1;
        end
    end

`ifdef IF_STACK_CHECK_EN
    logic ovf_q, unf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (push_en && !pop_en && stk_full)
                ovf_q <= 1'b1;
            if (pop_en && !push_en && stk_empty)
                unf_q <= 1'b1;
        end
    end

    assign stack_overflow  = ovf_q;
    assign stack_underflow = unf_q;
`else
    logic unused_full;
    assign unused_full     = stk_full;
    assign stack_overflow  = 1'b0;
    assign stack_underflow = 1'b0;
`endif
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed and randomized checks of if_stage against a queue-based fetch model.
module tb_if_stage;
    import if_stage_pkg::*;

    localparam int PL = 12;
    localparam int DEPTH = 8;
    localparam int IL = INSTR_LEN;
`ifdef IF_STACK_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1, stall = 1'b0, flush = 1'b0, redirect_en = 1'b0, push_en = 1'b0, pop_en = 1'b0;
    logic [PL-1:0] redirect_pc = '0, push_pc = '0, imem_addr, PR1_pc;
    logic [IL-1:0] imem_data, PR1_instruction;
    logic PR1_valid, stack_overflow, stack_underflow;

    if_stage #(.PC_LEN(PL), .STACK_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .redirect_en(redirect_en), .redirect_pc(redirect_pc),
        .push_en(push_en), .push_pc(push_pc), .pop_en(pop_en),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .PR1_instruction(PR1_instruction), .PR1_pc(PR1_pc), .PR1_valid(PR1_valid),
        .stack_overflow(stack_overflow), .stack_underflow(stack_underflow)
    );

    always #5 clk = ~clk;

    function automatic logic [IL-1:0] pat(input logic [PL-1:0] a);
        return IL'({a, 8'h5A, ~a});
    endfunction

    assign imem_data = pat(imem_addr);

    int n_cmp = 0, n_bad = 0;

    logic [PL-1:0] m_pc, m_ppc;
    logic [IL-1:0] m_ins;
    logic m_val, m_ovf, m_unf;
    logic [PL-1:0] m_stk[$];

    task automatic idle();
        rst = 0; stall = 0; flush = 0; redirect_en = 0; push_en = 0; pop_en = 0;
    endtask

    // Advance the model by the rules of the fetch stage, then clock the DUT.
    task automatic step();
        logic [PL-1:0] npc;
        if (rst) begin
            m_pc = '0; m_ppc = '0; m_ins = '0; m_val = 0; m_ovf = 0; m_unf = 0;
            m_stk.delete();
        end else begin
            if (flush) begin
                m_ins = '0; m_ppc = '0; m_val = 0;
            end else if (!stall) begin
                m_ins = pat(m_pc); m_ppc = m_pc + 1'b1; m_val = 1;
            end
            npc = redirect_en ? redirect_pc : stall ? m_pc : m_pc + 1'b1;
            if (push_en && pop_en) begin
                if (m_stk.size() == 0) npc = push_pc;
                else begin
                    npc = m_stk[m_stk.size()-1];
                    m_stk[m_stk.size()-1] = push_pc;
                end
            end else if (pop_en) begin
                if (m_stk.size() > 0) npc = m_stk.pop_back();
                else m_unf = 1;
            end else if (push_en) begin
                if (m_stk.size() < DEPTH) m_stk.push_back(push_pc);
                else m_ovf = 1;
            end
            m_pc = npc;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle(); rst = 1; step(); rst = 0;
    endtask

    task automatic test_reset();
        rst = 1; stall = 1; flush = 0; redirect_en = 1; redirect_pc = 12'h3C3;
        push_en = 1; push_pc = 12'h111; pop_en = 1;
        step(); idle();
        n_cmp++; if (imem_addr !== 12'h000) begin n_bad++; $display("FAIL reset_addr got %h want 000", imem_addr); end
        n_cmp++; if (PR1_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", PR1_valid); end
        n_cmp++; if (PR1_pc !== 12'h000) begin n_bad++; $display("FAIL reset_pr1pc got %h want 000", PR1_pc); end
        n_cmp++; if (PR1_instruction !== NOP) begin n_bad++; $display("FAIL reset_instr got %h want %h", PR1_instruction, NOP); end
        n_cmp++; if ({stack_overflow, stack_underflow} !== 2'b00) begin n_bad++; $display("FAIL reset_flags got %b%b want 00", stack_overflow, stack_underflow); end
    endtask

    task automatic test_fetch();
        do_reset();
        for (int k = 1; k <= 3; k++) begin
            step();
            n_cmp++; if (imem_addr !== PL'(k)) begin n_bad++; $display("FAIL fetch_addr%0d got %h want %h", k, imem_addr, PL'(k)); end
            n_cmp++; if (PR1_pc !== PL'(k)) begin n_bad++; $display("FAIL fetch_pr1pc%0d got %h want %h", k, PR1_pc, PL'(k)); end
            n_cmp++; if (PR1_valid !== 1'b1) begin n_bad++; $display("FAIL fetch_valid%0d got %b want 1", k, PR1_valid); end
            n_cmp++; if (PR1_instruction !== pat(PL'(k-1))) begin n_bad++; $display("FAIL fetch_instr%0d got %h want %h", k, PR1_instruction, pat(PL'(k-1))); end
        end
    endtask

    task automatic test_redirect_stall();
        logic [PL-1:0] hold_pc = m_ppc;
        logic [IL-1:0] hold_ins = m_ins;
        stall = 1; redirect_en = 1; redirect_pc = 12'h0A0;
        step(); idle();
        n_cmp++; if (imem_addr !== 12'h0A0) begin n_bad++; $display("FAIL redir_addr got %h want 0a0", imem_addr); end
        n_cmp++; if (PR1_pc !== hold_pc || PR1_instruction !== hold_ins || PR1_valid !== 1'b1) begin
            n_bad++; $display("FAIL redir_hold got %h/%h/%b want %h/%h/1", PR1_pc, PR1_instruction, PR1_valid, hold_pc, hold_ins);
        end
    endtask

    task automatic test_stack_pop();
        do_reset();
        push_en = 1; push_pc = 12'h011; step();
        push_pc = 12'h022; step(); idle();
        pop_en = 1; step();
        n_cmp++; if (imem_addr !== 12'h022) begin n_bad++; $display("FAIL pop1 got %h want 022", imem_addr); end
        step();
        n_cmp++; if (imem_addr !== 12'h011) begin n_bad++; $display("FAIL pop2 got %h want 011", imem_addr); end
        n_cmp++; if (stack_underflow !== 1'b0) begin n_bad++; $display("FAIL unf_early got %b want 0", stack_underflow); end
        step(); idle();
        n_cmp++; if (imem_addr !== 12'h012) begin n_bad++; $display("FAIL pop3 got %h want 012", imem_addr); end
        n_cmp++; if (stack_underflow !== CHK) begin n_bad++; $display("FAIL unf got %b want %b", stack_underflow, CHK); end
        step();
        n_cmp++; if (stack_underflow !== CHK) begin n_bad++; $display("FAIL unf_sticky got %b want %b", stack_underflow, CHK); end
    endtask

    task automatic test_overflow();
        do_reset();
        push_en = 1;
        for (int i = 1; i <= 9; i++) begin
            push_pc = PL'(i); step();
            n_cmp++; if (stack_overflow !== (i == 9 ? CHK : 1'b0)) begin n_bad++; $display("FAIL ovf%0d got %b want %b", i, stack_overflow, i == 9 ? CHK : 1'b0); end
        end
        idle(); pop_en = 1;
        for (int j = 0; j < 8; j++) begin
            step();
            n_cmp++; if (imem_addr !== PL'(8 - j)) begin n_bad++; $display("FAIL ovf_pop%0d got %h want %h", j, imem_addr, PL'(8 - j)); end
        end
        idle();
    endtask

    task automatic test_wrap();
        redirect_en = 1; redirect_pc = 12'hFFF; step(); idle();
        n_cmp++; if (imem_addr !== 12'hFFF) begin n_bad++; $display("FAIL wrap_set got %h want fff", imem_addr); end
        step();
        n_cmp++; if (imem_addr !== 12'h000) begin n_bad++; $display("FAIL wrap_addr got %h want 000", imem_addr); end
        n_cmp++; if (PR1_pc !== 12'h000 || PR1_instruction !== pat(12'hFFF)) begin
            n_bad++; $display("FAIL wrap_pr1 got %h/%h want 000/%h", PR1_pc, PR1_instruction, pat(12'hFFF));
        end
    endtask

    task automatic test_flush_swap();
        do_reset();
        push_en = 1; push_pc = 12'h033; step(); idle();
        flush = 1; stall = 1; step(); idle();
        n_cmp++; if (PR1_valid !== 1'b0 || PR1_instruction !== NOP || PR1_pc !== 12'h000) begin
            n_bad++; $display("FAIL flush_pr1 got %b/%h/%h want 0/0/000", PR1_valid, PR1_instruction, PR1_pc);
        end
        n_cmp++; if (imem_addr !== 12'h001) begin n_bad++; $display("FAIL flush_hold got %h want 001", imem_addr); end
        push_en = 1; pop_en = 1; push_pc = 12'h055; step(); idle();
        n_cmp++; if (imem_addr !== 12'h033) begin n_bad++; $display("FAIL swap_pc got %h want 033", imem_addr); end
        pop_en = 1; step(); idle();
        n_cmp++; if (imem_addr !== 12'h055) begin n_bad++; $display("FAIL swap_top got %h want 055", imem_addr); end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 59) == 0);
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 7) == 0);
            redirect_en = ($urandom_range(0, 5) == 0);
            redirect_pc = PL'($urandom);
            push_en = ($urandom_range(0, 2) == 0);
            pop_en = ($urandom_range(0, 2) == 0);
            push_pc = PL'($urandom);
            step();
            n_cmp++; if (imem_addr !== m_pc) begin n_bad++; $display("FAIL rnd_addr c%0d got %h want %h", c, imem_addr, m_pc); end
            n_cmp++; if (PR1_pc !== m_ppc) begin n_bad++; $display("FAIL rnd_pr1pc c%0d got %h want %h", c, PR1_pc, m_ppc); end
            n_cmp++; if (PR1_instruction !== m_ins) begin n_bad++; $display("FAIL rnd_instr c%0d got %h want %h", c, PR1_instruction, m_ins); end
            n_cmp++; if (PR1_valid !== m_val) begin n_bad++; $display("FAIL rnd_valid c%0d got %b want %b", c, PR1_valid, m_val); end
            n_cmp++; if ({stack_overflow, stack_underflow} !== ({m_ovf, m_unf} & {CHK, CHK})) begin
                n_bad++; $display("FAIL rnd_flags c%0d got %b%b want %b%b", c, stack_overflow, stack_underflow, m_ovf & CHK, m_unf & CHK);
            end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_redirect_stall();
        test_stack_pop();
        test_overflow();
        test_wrap();
        test_flush_swap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
